// File: rtl/multicycle_ctrl_fsm_pkg.sv
// Shared encodings for the multi-cycle sequencer: states, trap causes, class bit order.
package ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH   = 3'd0,
    ST_DECODE  = 3'd1,
    ST_EXECUTE = 3'd2,
    ST_MEM     = 3'd3,
    ST_WB      = 3'd4,
    ST_BOOT    = 3'd6,
    ST_TRAP    = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    CAUSE_NONE    = 2'b00,
    CAUSE_ILLEGAL = 2'b01,
    CAUSE_IMEM_TO = 2'b10,
    CAUSE_DMEM_TO = 2'b11
  } cause_t;

  localparam int CLASS_W    = 9;
  localparam int CLS_R      = 0;
  localparam int CLS_I      = 1;
  localparam int CLS_STORE  = 2;
  localparam int CLS_BRANCH = 3;
  localparam int CLS_LOAD   = 4;
  localparam int CLS_AUIPC  = 5;
  localparam int CLS_LUI    = 6;
  localparam int CLS_JAL    = 7;
  localparam int CLS_JALR   = 8;

  function automatic logic is_one_hot(input logic [CLASS_W-1:0] v);
    logic [3:0] n;
    n = 4'd0;
    for (int k = 0; k < CLASS_W; k++) begin
      n = n + {3'd0, v[k]};
    end
    return (n == 4'd1);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_mem_timeout_cnt.sv
// Wait-cycle counter for a memory request; flags expiry when the limit is hit without ack.
module mem_timeout_cnt
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  input  logic ack,
  output logic expired
);

  logic [15:0] count_r;

  // Count unacknowledged request cycles; cleared whenever the FSM changes state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 16'd0;
    end else if (clear) begin
      count_r <= 16'd0;
    end else if (enable && !ack) begin
      count_r <= count_r + 16'd1;
    end else begin
      count_r <= count_r;
    end
  end

  // An ack in the limit cycle suppresses expiry.
  assign expired = enable && !ack && (count_r == 16'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// Multi-cycle RV32I sequencer: FETCH/DECODE/EXECUTE/MEM/WB with illegal-class and
// memory-timeout traps and a retired-instruction counter.
module multicycle_ctrl_fsm
  import ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255,
  parameter int INSTRET_W   = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r_type,
  input  logic                 i_type,
  input  logic                 store,
  input  logic                 branch,
  input  logic                 load,
  input  logic                 auipc,
  input  logic                 lui,
  input  logic                 jal,
  input  logic                 jalr,
  input  logic                 imem_ack,
  input  logic                 dmem_ack,
  output logic                 imem_req,
  output logic                 ir_we,
  output logic                 dmem_req,
  output logic                 dmem_we,
  output logic                 rf_we,
  output logic                 pc_we,
  output logic [INSTRET_W-1:0] instret,
  output logic [2:0]           state_o,
  output logic                 trap,
  output logic [1:0]           trap_cause
);

  state_t                 state_r;
  state_t                 next_s;
  cause_t                 cause_r;
  cause_t                 trap_code_s;
  logic [CLASS_W-1:0]     class_r;
  logic [CLASS_W-1:0]     flags_s;
  logic [INSTRET_W-1:0]   instret_r;
  logic                   ack_s;
  logic                   expired_s;

  assign flags_s = {jalr, jal, lui, auipc, load, branch, store, i_type, r_type};
  assign ack_s   = (state_r == ST_FETCH) ? imem_ack : dmem_ack;

  mem_timeout_cnt #(
    .TIMEOUT_CYC(TIMEOUT_CYC)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (next_s != state_r),
    .enable  (imem_req | dmem_req),
    .ack     (ack_s),
    .expired (expired_s)
  );

  // Next-state and per-phase enables; only ir_we and pc_we depend on ack.
  always_comb begin
    next_s      = state_r;
    trap_code_s = CAUSE_NONE;
    imem_req    = 1'b0;
    ir_we       = 1'b0;
    dmem_req    = 1'b0;
    dmem_we     = 1'b0;
    rf_we       = 1'b0;
    pc_we       = 1'b0;
    case (state_r)
      ST_BOOT: begin
        next_s = ST_FETCH;
      end
      ST_FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          ir_we  = 1'b1;
          next_s = ST_DECODE;
        end else if (expired_s) begin
          next_s      = ST_TRAP;
          trap_code_s = CAUSE_IMEM_TO;
        end else begin
          next_s = ST_FETCH;
        end
      end
      ST_DECODE: begin
        if (is_one_hot(flags_s)) begin
          next_s = ST_EXECUTE;
        end else begin
          next_s      = ST_TRAP;
          trap_code_s = CAUSE_ILLEGAL;
        end
      end
      ST_EXECUTE: begin
        if (class_r[CLS_LOAD] || class_r[CLS_STORE]) begin
          next_s = ST_MEM;
        end else if (class_r[CLS_BRANCH]) begin
          pc_we  = 1'b1;
          next_s = ST_FETCH;
        end else begin
          next_s = ST_WB;
        end
      end
      ST_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = class_r[CLS_STORE];
        if (dmem_ack) begin
          if (class_r[CLS_STORE]) begin
            pc_we  = 1'b1;
            next_s = ST_FETCH;
          end else begin
            next_s = ST_WB;
          end
        end else if (expired_s) begin
          next_s      = ST_TRAP;
          trap_code_s = CAUSE_DMEM_TO;
        end else begin
          next_s = ST_MEM;
        end
      end
      ST_WB: begin
        rf_we  = 1'b1;
        pc_we  = 1'b1;
        next_s = ST_FETCH;
      end
      ST_TRAP: begin
        next_s = ST_TRAP;
      end
      default: begin
        next_s      = ST_TRAP;
        trap_code_s = CAUSE_ILLEGAL;
      end
    endcase
  end

  // State, latched class, trap cause and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r   <= ST_BOOT;
      class_r   <= '0;
      cause_r   <= CAUSE_NONE;
      instret_r <= '0;
    end else begin
      state_r   <= next_s;
      class_r   <= (state_r == ST_DECODE) ? flags_s : class_r;
      cause_r   <= (state_r != ST_TRAP && next_s == ST_TRAP) ? trap_code_s : cause_r;
      instret_r <= pc_we ? instret_r + {{(INSTRET_W-1){1'b0}}, 1'b1} : instret_r;
    end
  end

  assign instret    = instret_r;
  assign state_o    = state_r;
  assign trap       = (state_r == ST_TRAP);
  assign trap_cause = cause_r;

endmodule
